rx_sample_unpacker: RTL and testbench
=====================================

# rx_sample_unpacker

Consumes 16-bit packed words from the show-ahead receive data FIFO on the FIFO read-clock side. Serialises each word into eight 2-bit (sign, magnitude) GPS front-end samples, one per `sample_strobe`, for the acquisition/tracking datapath. Drives the FIFO read request and detects and reports starvation (underrun).

## Interface
- `UNDERRUN_CNT_WIDTH`, 16, width of the saturating underrun counter.
- `clk`  in  1  single clock; the receive FIFO read clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `enable`  in  1  level; 1 = stream samples, 0 = idle and discard any partial word.
- `sample_strobe`  in  1  one-cycle tick per required output sample; may be asserted on consecutive cycles.
- `fifo_q`  in  16  FIFO show-ahead data; valid whenever `fifo_rdempty`=0.
- `fifo_rdempty`  in  1  FIFO empty flag, read side.
- `fifo_rdreq`  out  1  pop request to the FIFO.
- `sample_valid`  out  1  one-cycle pulse; `sample_sign`/`sample_mag` are valid.
- `sample_sign`  out  1  sample sign bit.
- `sample_mag`  out  1  sample magnitude bit.
- `underrun`  out  1  sticky; set when a strobe finds no data.
- `clear_underrun`  in  1  clears `underrun` and the counter.
- `underrun_count`  out  `UNDERRUN_CNT_WIDTH`  saturating count of starved strobes. Present only with `RX_UNPACK_STATS_EN`.

## Operation
- Holding register `word_reg[15:0]`, flag `word_valid`, 3-bit index `idx`. Sample i is `sign = word_reg[15-2i]` and `mag = word_reg[14-2i]`, so the MSB pair goes first.
- States:
  - IDLE: entered from reset or `enable`=0. Moves to PRIME when `enable`=1.
  - PRIME: waits for `fifo_rdempty`=0, then loads `word_reg <= fifo_q`, pulses `fifo_rdreq`, sets `idx`=0 and `word_valid`=1, and moves to RUN. A strobe seen in PRIME is ignored, with no underrun.
  - RUN, strobe with `word_valid`=1: emits sample `idx` and increments `idx`.
    - At `idx`=7 with `fifo_rdempty`=0: in the same cycle loads the next word, pulses `fifo_rdreq` and wraps `idx` to 0. There is no bubble.
    - At `idx`=7 with `fifo_rdempty`=1: clears `word_valid`.
  - RUN, `word_valid`=0, no strobe, `fifo_rdempty`=0: loads the word, pulses `fifo_rdreq`, sets `idx`=0.
  - RUN, strobe with `word_valid`=0: underrun. No `sample_valid`, sets `underrun`, increments the counter (saturating at all-ones). If `fifo_rdempty`=0 in that same cycle, the word is still loaded with `idx`=0; the starved strobe is not replayed.
- `enable` falling in any state: go to IDLE next cycle and clear `word_valid`. No `fifo_rdreq` in that cycle. Unconsumed samples are dropped.
- `clear_underrun` in the same cycle as a new underrun: the clear wins, so flag and count are 0 after the edge.
- `fifo_rdreq` is never asserted while `fifo_rdempty`=1. It is at most one pulse per consumed word.

## Timing
- Reset values: `fifo_rdreq`=0, `sample_valid`=0, `sample_sign`=0, `sample_mag`=0, `underrun`=0, `underrun_count`=0. State is IDLE.
- `sample_valid`, `sample_sign`, `sample_mag` are registered and appear 1 cycle after the `sample_strobe` edge. Data holds until the next valid.
- `fifo_rdreq` is combinational from registered state and `fifo_rdempty`. It is sampled by the FIFO on the same `clk` edge that captures `fifo_q` into `word_reg`.
- From `enable` rising with a non-empty FIFO, the first strobe is serviced from the 3rd cycle: IDLE→PRIME, then PRIME load, then RUN.
- Sustained throughput is 1 sample/cycle; a word lasts exactly 8 strobes.
- Reset mid-word: the word is lost and the FIFO is not popped during reset.

## Configuration
- `RX_UNPACK_STATS_EN` defined: adds the `underrun_count` port and its saturating counter.
- Not defined: the port and counter are absent. The `underrun` sticky flag and `clear_underrun` still behave as above.

## Structure
- The shared package `gps_rt_data_pkg` holds:
  - the state enum (IDLE, PRIME, RUN);
  - `RX_WORD_WIDTH`=16;
  - `RX_SAMPLES_PER_WORD`=8;
  - `RX_SAMPLE_BITS`=2.
- One natural sub-module, `sat_counter`: a saturating counter with increment and clear inputs, instantiated under `RX_UNPACK_STATS_EN`.

## Test plan
- FIFO preloaded with 0xE41B, enable=1, then 8 strobes one cycle apart. Required:
  - sign/mag sequence (1,1),(1,0),(0,1),(0,0),(0,0),(0,1),(1,0),(1,1);
  - exactly one `fifo_rdreq`;
  - no underrun.
- Two words 0xFFFF then 0x0000, 16 back-to-back strobes. Required: 8 samples (1,1) then 8 samples (0,0), `sample_valid` continuous, second `fifo_rdreq` on the 8th strobe cycle.
- One word, then 10 strobes with the FIFO otherwise empty. Required: 8 valid samples, `underrun`=1, `underrun_count`=2.
- Under the previous scenario's conditions, `clear_underrun` asserted in the same cycle as the 10th strobe. Required: `underrun`=0 and `underrun_count`=0 afterwards.
- `enable` dropped after 3 samples of 0xAAAA, then re-enabled with 0x5555 queued. Required: the 0xAAAA remainder is dropped and the next samples are (0,1)×8.
- `reset` asserted mid-word with strobes active. Required: all outputs 0 the next cycle, no `fifo_rdreq`, state IDLE.

Source files
------------

// File: rtl/gps_rt_data_pkg.sv
// rtl/gps_rt_data_pkg.sv - shared receive-datapath types, sizes and sample extraction helper
package gps_rt_data_pkg;

  localparam int RX_WORD_WIDTH       = 16;
  localparam int RX_SAMPLES_PER_WORD = 8;
  localparam int RX_SAMPLE_BITS      = 2;
  localparam int RX_IDX_WIDTH        = $clog2(RX_SAMPLES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } rx_state_e;

  // Returns {sign, mag} of sample idx; sample 0 is the most significant pair.
  function automatic logic [RX_SAMPLE_BITS-1:0] pick_sample(
    input logic [RX_WORD_WIDTH-1:0] word,
    input logic [RX_IDX_WIDTH-1:0]  idx
  );
    logic [RX_WORD_WIDTH-1:0] shifted;
    shifted = word << (RX_SAMPLE_BITS * idx);
    return shifted[RX_WORD_WIDTH-1 -: RX_SAMPLE_BITS];
  endfunction

endpackage

// File: rtl/rx_sample_unpacker_if.sv
// rtl/rx_sample_unpacker_if.sv - show-ahead FIFO read port and serial sample stream
interface rx_sample_unpacker_if;
  import gps_rt_data_pkg::*;

  logic [RX_WORD_WIDTH-1:0] fifo_q;
  logic                     fifo_rdempty;
  logic                     fifo_rdreq;
  logic                     sample_strobe;
  logic                     sample_valid;
  logic                     sample_sign;
  logic                     sample_mag;

  modport master (
    input  fifo_q,
    input  fifo_rdempty,
    input  sample_strobe,
    output fifo_rdreq,
    output sample_valid,
    output sample_sign,
    output sample_mag
  );

  modport slave (
    output fifo_q,
    output fifo_rdempty,
    output sample_strobe,
    input  fifo_rdreq,
    input  sample_valid,
    input  sample_sign,
    input  sample_mag
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear priority over increment
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rx_sample_unpacker.sv
// rtl/rx_sample_unpacker.sv - serialises 16-bit FIFO words into 2-bit sign/mag samples
// RX_UNPACK_STATS_EN adds the saturating underrun_count output.
module rx_sample_unpacker
  import gps_rt_data_pkg::*;
`ifdef RX_UNPACK_STATS_EN
#(
  parameter int UNDERRUN_CNT_WIDTH = 16
)
`endif
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear_underrun,
  output logic                          underrun,
`ifdef RX_UNPACK_STATS_EN
  output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count,
`endif
  rx_sample_unpacker_if.master          bus
);

  localparam logic [RX_IDX_WIDTH-1:0] LAST_IDX = RX_IDX_WIDTH'(RX_SAMPLES_PER_WORD - 1);

  rx_state_e                state_q, state_d;
  logic [RX_WORD_WIDTH-1:0] word_q, word_d;
  logic                     word_valid_q, word_valid_d;
  logic [RX_IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                     sample_valid_q, sample_valid_d;
  logic                     sample_sign_q, sample_sign_d;
  logic                     sample_mag_q, sample_mag_d;
  logic                     underrun_q, underrun_d;

  logic                      load;
  logic                      rdreq;
  logic                      underrun_event;
  logic [RX_SAMPLE_BITS-1:0] pair;

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    word_valid_d   = word_valid_q;
    idx_d          = idx_q;
    sample_valid_d = 1'b0;
    sample_sign_d  = sample_sign_q;
    sample_mag_d   = sample_mag_q;
    load           = 1'b0;
    rdreq          = 1'b0;
    underrun_event = 1'b0;
    pair           = pick_sample(word_q, idx_q);

    if (!enable) begin
      // Any partial word is dropped; the FIFO is not touched this cycle.
      state_d      = ST_IDLE;
      word_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_PRIME;
        ST_PRIME: begin
          if (!bus.fifo_rdempty) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.sample_strobe) begin
            if (word_valid_q) begin
              sample_valid_d = 1'b1;
              sample_sign_d  = pair[1];
              sample_mag_d   = pair[0];
              idx_d          = idx_q + 1'b1;
              if (idx_q == LAST_IDX) begin
                if (!bus.fifo_rdempty) begin
                  load = 1'b1;
                end else begin
                  word_valid_d = 1'b0;
                end
              end
            end else begin
              // Starved strobe: counted, never replayed, but a fresh word still loads.
              underrun_event = 1'b1;
              load           = !bus.fifo_rdempty;
            end
          end else if (!word_valid_q && !bus.fifo_rdempty) begin
            load = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (load) begin
      word_d       = bus.fifo_q;
      idx_d        = '0;
      word_valid_d = 1'b1;
      rdreq        = 1'b1;
    end

    underrun_d = clear_underrun ? 1'b0 : (underrun_q | underrun_event);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      word_q         <= '0;
      word_valid_q   <= 1'b0;
      idx_q          <= '0;
      sample_valid_q <= 1'b0;
      sample_sign_q  <= 1'b0;
      sample_mag_q   <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_q         <= word_d;
      word_valid_q   <= word_valid_d;
      idx_q          <= idx_d;
      sample_valid_q <= sample_valid_d;
      sample_sign_q  <= sample_sign_d;
      sample_mag_q   <= sample_mag_d;
      underrun_q     <= underrun_d;
    end
  end

`ifdef RX_UNPACK_STATS_EN
  sat_counter #(
    .WIDTH (UNDERRUN_CNT_WIDTH)
  ) u_underrun_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (underrun_event),
    .clr   (clear_underrun),
    .count (underrun_count)
  );
`endif

  // The FIFO must never see a pop while reset holds the word register.
  assign bus.fifo_rdreq   = rdreq & ~reset;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_sign  = sample_sign_q;
  assign bus.sample_mag   = sample_mag_q;
  assign underrun         = underrun_q;

endmodule

// File: tb/tb_rx_sample_unpacker.sv
// tb/tb_rx_sample_unpacker.sv - directed self-checking bench for rx_sample_unpacker
module tb_rx_sample_unpacker;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic clear_underrun;
  logic underrun;
`ifdef RX_UNPACK_STATS_EN
  logic [15:0] underrun_count;
`endif

  rx_sample_unpacker_if ifc ();

  rx_sample_unpacker dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .clear_underrun (clear_underrun),
    .underrun       (underrun),
`ifdef RX_UNPACK_STATS_EN
    .underrun_count (underrun_count),
`endif
    .bus            (ifc.master)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model
  logic [15:0] mem [0:15];
  int wr_ptr    = 0;
  int rd_ptr    = 0;
  int pop_count = 0;
  int bad_pop   = 0;

  assign ifc.fifo_rdempty = (wr_ptr == rd_ptr);
  assign ifc.fifo_q       = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (ifc.fifo_rdreq) begin
      if (wr_ptr == rd_ptr) begin
        bad_pop <= bad_pop + 1;
      end else begin
        rd_ptr    <= rd_ptr + 1;
        pop_count <= pop_count + 1;
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr++;
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    enable            = 1'b0;
    clear_underrun    = 1'b0;
    ifc.sample_strobe = 1'b0;
    tick();
    reset  = 1'b0;
    wr_ptr = rd_ptr;
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
    tick();
  endtask

  // Back-to-back strobes; collects valid samples as packed {sign,mag} pairs.
  task automatic run_strobes(input int n, output logic [31:0] pairs,
                             output logic [15:0] valids, output logic [15:0] rdreqs);
    pairs  = '0;
    valids = '0;
    rdreqs = '0;
    for (int i = 0; i < n; i++) begin
      ifc.sample_strobe = 1'b1;
      #1;
      rdreqs[i] = ifc.fifo_rdreq;
      @(posedge clk);
      #1;
      valids[i] = ifc.sample_valid;
      if (ifc.sample_valid) pairs = {pairs[29:0], ifc.sample_sign, ifc.sample_mag};
    end
    ifc.sample_strobe = 1'b0;
  endtask

  logic [31:0] pairs;
  logic [15:0] valids;
  logic [15:0] rdreqs;
  int          p0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    do_reset();
    check("rst_valid", {31'd0, ifc.sample_valid}, 32'd0);
    check("rst_sign", {31'd0, ifc.sample_sign}, 32'd0);
    check("rst_mag", {31'd0, ifc.sample_mag}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_rdreq", {31'd0, ifc.fifo_rdreq}, 32'd0);
`ifdef RX_UNPACK_STATS_EN
    check("rst_count", {16'd0, underrun_count}, 32'd0);
`endif

    // Single word, MSB pair first
    push(16'hE41B);
    p0 = pop_count;
    start();
    run_strobes(8, pairs, valids, rdreqs);
    check("e41b_samples", pairs, 32'h0000_E41B);
    check("e41b_valids", {16'd0, valids}, 32'h0000_00FF);
    check("e41b_pops", pop_count - p0, 32'd1);
    check("e41b_underrun", {31'd0, underrun}, 32'd0);

    // Two words back-to-back, no bubble at the boundary
    do_reset();
    push(16'hFFFF);
    push(16'h0000);
    p0 = pop_count;
    start();
    run_strobes(16, pairs, valids, rdreqs);
    check("b2b_samples", pairs, 32'hFFFF_0000);
    check("b2b_valids", {16'd0, valids}, 32'h0000_FFFF);
    check("b2b_rdreq_pos", {16'd0, rdreqs}, 32'h0000_0080);
    check("b2b_pops", pop_count - p0, 32'd2);
    check("b2b_underrun", {31'd0, underrun}, 32'd0);

    // Starvation after one word
    do_reset();
    push(16'h9C63);
    start();
    run_strobes(10, pairs, valids, rdreqs);
    check("starve_samples", pairs, 32'h0000_9C63);
    check("starve_valids", {16'd0, valids}, 32'h0000_00FF);
    check("starve_underrun", {31'd0, underrun}, 32'd1);
`ifdef RX_UNPACK_STATS_EN
    check("starve_count", {16'd0, underrun_count}, 32'd2);
`endif

    // Clear coincident with a new underrun wins
    do_reset();
    push(16'h9C63);
    start();
    run_strobes(9, pairs, valids, rdreqs);
    check("clr_pre_underrun", {31'd0, underrun}, 32'd1);
    clear_underrun    = 1'b1;
    ifc.sample_strobe = 1'b1;
    tick();
    clear_underrun    = 1'b0;
    ifc.sample_strobe = 1'b0;
    check("clr_valid", {31'd0, ifc.sample_valid}, 32'd0);
    check("clr_underrun", {31'd0, underrun}, 32'd0);
`ifdef RX_UNPACK_STATS_EN
    check("clr_count", {16'd0, underrun_count}, 32'd0);
`endif

    // Enable drop discards the remainder of the current word
    do_reset();
    push(16'hAAAA);
    p0 = pop_count;
    start();
    run_strobes(3, pairs, valids, rdreqs);
    check("en_first3", pairs, 32'h0000_002A);
    enable = 1'b0;
    push(16'h5555);
    tick();
    check("en_drop_rdreq", {31'd0, ifc.fifo_rdreq}, 32'd0);
    start();
    run_strobes(8, pairs, valids, rdreqs);
    check("en_next_samples", pairs, 32'h0000_5555);
    check("en_next_valids", {16'd0, valids}, 32'h0000_00FF);
    check("en_pops", pop_count - p0, 32'd2);

    // Reset mid-word, at the word boundary where a pop would otherwise fire
    do_reset();
    push(16'h123C);
    push(16'hFFFF);
    start();
    run_strobes(7, pairs, valids, rdreqs);
    check("mid_pre_pair", {30'd0, ifc.sample_sign, ifc.sample_mag}, 32'd3);
    ifc.sample_strobe = 1'b1;
    reset             = 1'b1;
    #1;
    check("mid_rst_rdreq", {31'd0, ifc.fifo_rdreq}, 32'd0);
    p0 = pop_count;
    @(posedge clk);
    #1;
    check("mid_rst_pops", pop_count - p0, 32'd0);
    check("mid_rst_valid", {31'd0, ifc.sample_valid}, 32'd0);
    check("mid_rst_sign", {31'd0, ifc.sample_sign}, 32'd0);
    check("mid_rst_mag", {31'd0, ifc.sample_mag}, 32'd0);
    check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
    reset             = 1'b0;
    ifc.sample_strobe = 1'b0;
    #1;
    check("mid_idle_rdreq", {31'd0, ifc.fifo_rdreq}, 32'd0);
    tick();
    check("mid_prime_rdreq", {31'd0, ifc.fifo_rdreq}, 32'd1);

    check("no_pop_when_empty", bad_pop, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
